// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx serial receive front end.
// Holds the FSM state encoding, frame width, and default bit timing.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam int DATA_BITS = 8;
  // 39.75 MHz core clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 345;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
// The reset value is chosen per use so the idle level is presented out of reset.
module uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises the RX pin, samples mid-bit, and hands
// bytes to the core through a one-entry holding register with sticky errors.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk_core,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clear,
  output logic [2:0]           dbg_state
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  state_t               r_state;
  state_t               w_next;
  logic [TW-1:0]        r_timer;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rxs;
  logic w_tick;
  logic w_shift;
  logic w_load;
  logic w_overrun_set;
  logic w_frame_set;
  logic w_xfer;

  uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (clk_core),
    .i_rst_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rxs)
  );

  assign w_tick = (r_timer == '0);
  // Handshake: a byte transfers on any cycle with rx_valid && rx_ready; rx_data
  // is stable while rx_valid is high, and a load in a transfer cycle replaces it.
  assign w_xfer = r_valid && rx_ready;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_shift       = 1'b0;
    w_load        = 1'b0;
    w_overrun_set = 1'b0;
    w_frame_set   = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_rxs) w_next = ST_START;
      ST_START: if (w_tick) w_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            if (!r_valid || rx_ready) w_load = 1'b1;
            else                      w_overrun_set = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_next      = ST_BREAK;
          end
        end
      end
      ST_BREAK: if (w_rxs) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Idle keeps the half-bit preload so the first tick lands mid start bit.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == ST_IDLE) r_timer <= TW'(HALF_BIT - 1);
      else if (w_tick)        r_timer <= TW'(CLKS_PER_BIT - 1);
      else                    r_timer <= r_timer - 1'b1;

      if (r_state == ST_START) r_bit_idx <= '0;
      else if (w_shift)        r_bit_idx <= r_bit_idx + 1'b1;

      if (w_shift) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) r_data <= r_shift;

      if (w_load)      r_valid <= 1'b1;
      else if (w_xfer) r_valid <= 1'b0;

      // A new error event wins over a clear in the same cycle.
      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;

      if (w_overrun_set)  r_overrun <= 1'b1;
      else if (err_clear) r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx at 16 clocks per bit, with a
// frame-level reference model and a byte scoreboard on the consumer side.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB    = 16;
  localparam int HB     = 8;
  localparam int PERIOD = 10;
  // pin-to-rxs + half bit + nine bit periods to the stop sample + one clock
  localparam int LATENCY = 2 + HB + 9 * CPB + 1;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clear;
  logic [2:0] dbg_state;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic       m_fe;

  int         valid_rises;
  int         valid_falls;
  logic       prev_valid;
  logic       saw_start;
  logic       past_start;
  longint     last_start_t;
  longint     last_rise_t;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
    .clk_core  (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clear (err_clear),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    last_start_t = $time;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  // monitor + scoreboard: samples just after the negedge, once inputs are settled
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (dbg_state == ST_START) saw_start = 1'b1;
      if (dbg_state == ST_DATA || dbg_state == ST_STOP || dbg_state == ST_BREAK)
        past_start = 1'b1;
      if (rx_valid && !prev_valid) begin
        valid_rises++;
        last_rise_t = $time;
      end
      if (!rx_valid && prev_valid) valid_falls++;
      prev_valid = rx_valid;
      if (rx_valid && rx_ready) begin
        check("sb_have_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_byte", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] b1, b2, b;
    logic       bad;
    int         vr0, vf0, gap;

    n_checks = 0; n_fail = 0;
    valid_rises = 0; valid_falls = 0;
    saw_start = 1'b0; past_start = 1'b0;
    last_start_t = 0; last_rise_t = 0;
    m_fe = 1'b0;
    reset_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;

    idle_cycles(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    idle_cycles(CPB);

    // single byte, consumer always ready
    rx_ready = 1'b1;
    vr0 = valid_rises; vf0 = valid_falls;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle_cycles(CPB);
    check("a5_latency", 32'((last_rise_t - 1 - last_start_t) / PERIOD), 32'(LATENCY));
    check("a5_one_rise", 32'(valid_rises - vr0), 32'd1);
    check("a5_one_fall", 32'(valid_falls - vf0), 32'd1);
    check("a5_frame_err", 32'(frame_err), 32'd0);
    check("a5_overrun", 32'(overrun), 32'd0);

    // holding register full, second byte overruns
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_cycles(CPB);
    check("hold_valid", 32'(rx_valid), 32'd1);
    check("hold_data", 32'(rx_data), 32'h3C);
    send_frame(8'hC3, 1'b1);
    idle_cycles(CPB);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h3C);
    check("ovr_valid_kept", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    idle_cycles(1);
    check("ovr_drained", 32'(rx_valid), 32'd0);
    check("ovr_still_set", 32'(overrun), 32'd1);
    pulse_err_clear();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // short glitch on idle line
    saw_start = 1'b0; past_start = 1'b0; vr0 = valid_rises;
    glitch(4);
    idle_cycles(3 * CPB);
    check("glitch_reached_start", 32'(saw_start), 32'd1);
    check("glitch_not_past_start", 32'(past_start), 32'd0);
    check("glitch_no_valid", 32'(valid_rises - vr0), 32'd0);
    check("glitch_no_fe", 32'(frame_err), 32'd0);
    check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));

    // bad stop bit followed by a long break
    vr0 = valid_rises;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    idle_cycles(40 * CPB);
    check("brk_frame_err", 32'(frame_err), 32'd1);
    check("brk_state", 32'(dbg_state), 32'(ST_BREAK));
    check("brk_no_valid", 32'(valid_rises - vr0), 32'd0);
    rx = 1'b1;
    idle_cycles(2 * CPB);
    check("brk_exit_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    idle_cycles(CPB);
    check("brk_one_byte", 32'(valid_rises - vr0), 32'd1);
    pulse_err_clear();
    check("brk_fe_cleared", 32'(frame_err), 32'd0);

    // drain and load in the same cycle
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    if (b2 == b1) b2 = ~b1;
    rx_ready = 1'b0;
    exp_q.push_back(b1);
    send_frame(b1, 1'b1);
    idle_cycles(CPB);
    check("sim_first_data", 32'(rx_data), 32'(b1));
    vf0 = valid_falls;
    exp_q.push_back(b2);
    fork
      send_frame(b2, 1'b1);
      begin
        repeat (LATENCY - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle_cycles(CPB);
    check("sim_valid_held", 32'(rx_valid), 32'd1);
    check("sim_no_fall", 32'(valid_falls - vf0), 32'd0);
    check("sim_second_data", 32'(rx_data), 32'(b2));
    check("sim_no_overrun", 32'(overrun), 32'd0);
    rx_ready = 1'b1;
    idle_cycles(2);
    check("sim_drained", 32'(rx_valid), 32'd0);

    // reset in the middle of a frame
    vr0 = valid_rises;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + HB) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_data", 32'(rx_data), 32'd0);
        reset_n = 1'b1;
      end
    join
    idle_cycles(CPB);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle_cycles(CPB);
    check("mid_rst_one_byte", 32'(valid_rises - vr0), 32'd1);
    check("mid_rst_fe", 32'(frame_err), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);

    // randomised frames, glitches and bad stop bits
    m_fe = 1'b0;
    for (int f = 0; f < 16; f++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        glitch($urandom_range(1, 6));
        idle_cycles(CPB + HB);
      end
      if (bad) m_fe = 1'b1;
      else     exp_q.push_back(b);
      send_frame(b, !bad);
      gap = bad ? $urandom_range(1, 3) : $urandom_range(0, 3);
      idle_cycles(gap * CPB);
    end
    idle_cycles(2 * CPB);
    check("rand_frame_err", 32'(frame_err), 32'(m_fe));
    check("rand_overrun", 32'(overrun), 32'd0);
    check("rand_valid_idle", 32'(rx_valid), 32'd0);
    check("sb_all_delivered", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
